// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// EX-stage initiator for the multicycle divider. A DIV/DIVU sitting in EX is
// issued to the divider once: operands and alucontrol are latched and held
// stable for the whole divide. The pipeline is stalled until the divider
// reports ready. The result is then written to HI/LO with a one-cycle strobe.
// A pipeline flush during a divide annuls it. After a completed divide the
// block idles briefly (RELEASE), and after an annul it also idles briefly
// (DRAIN), so the divider always sees start low before any new issue.
//
// Optional feature (compile-time macro DIV_ZERO_FAST_EN):
//   When defined, a divide by zero seen in IDLE never starts the divider.
//   HI/LO is written on the next cycle with hi = dividend and
//   lo = 32'hFFFF_FFFF, and the instruction is not stalled.
//   When undefined, a zero divisor goes through the divider like any other
//   operand.
//
// Parameters
//   DRAIN_CYCLES    cycles spent in DRAIN after an annul (>= 2)
//   RELEASE_CYCLES  cycles spent in RELEASE after a result is taken (>= 1)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   div_valid_i       EX holds a DIV/DIVU (held while stall_o = 1)
//   alucontrol_i      DIV or DIVU control code, forwarded to the divider
//   src_a_i, src_b_i  dividend / divisor from EX
//   flush_i           pipeline flush, kills an in-flight divide
//   div_ready_i       divider ready
//   div_result_i      divider result {remainder, quotient}
//   div_start_o       divider start (held high for the whole divide)
//   div_annul_o       divider annul (combinational, one cycle)
//   div_alucontrol_o  latched alucontrol
//   div_op1_o         latched dividend
//   div_op2_o         latched divisor
//   stall_o           stall IF/ID/EX (combinational)
//   hilo_we_o         one-cycle HI/LO write strobe
//   hi_o, lo_o        remainder / quotient, valid with hilo_we_o
//   busy_o            controller is not IDLE
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int DRAIN_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid_i,
  input  logic [4:0]  alucontrol_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic [4:0]  div_alucontrol_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);

  localparam int CNT_MAX = (DRAIN_CYCLES > RELEASE_CYCLES) ? DRAIN_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_DRAIN   = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELEASE = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              hilo_we_q, hilo_we_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [4:0]        ctl_q, ctl_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic              annul_s;
  logic              zero_fast_s;

  // Zero-divisor shortcut is only taken when the fast path is compiled in.
`ifdef DIV_ZERO_FAST_EN
  assign zero_fast_s = (src_b_i == 32'd0);
`else
  assign zero_fast_s = 1'b0;
`endif

  // State, counter, handshake and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      start_q   <= 1'b0;
      hilo_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      ctl_q     <= 5'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      hilo_we_q <= hilo_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      ctl_q     <= ctl_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
    end
  end

  // Next-state, issue/annul decisions and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    hilo_we_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    ctl_d     = ctl_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    annul_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (div_valid_i && !flush_i) begin
          if (zero_fast_s) begin
            // Answer immediately; the divider is never started.
            hilo_we_d = 1'b1;
            hi_d      = src_a_i;
            lo_d      = 32'hFFFF_FFFF;
            start_d   = 1'b0;
          end else begin
            ctl_d   = alucontrol_i;
            op1_d   = src_a_i;
            op2_d   = src_b_i;
            start_d = 1'b1;
            state_d = ST_BUSY;
          end
        end else begin
          start_d = 1'b0;
        end
      end

      ST_BUSY: begin
        // Flush wins over a simultaneous ready: the result is discarded.
        if (flush_i) begin
          annul_s = 1'b1;
          start_d = 1'b0;
          cnt_d   = CNT_DRAIN;
          state_d = ST_DRAIN;
        end else if (div_ready_i) begin
          hilo_we_d = 1'b1;
          hi_d      = div_result_i[63:32];
          lo_d      = div_result_i[31:0];
          start_d   = 1'b0;
          cnt_d     = CNT_RELEASE;
          state_d   = ST_RELEASE;
        end else begin
          start_d = 1'b1;
        end
      end

      ST_RELEASE, ST_DRAIN: begin
        // The state lasts exactly cnt cycles; the last one returns to IDLE.
        start_d = 1'b0;
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Stall while a DIV is waiting to issue or waiting for its result; it drops
  // in the cycle ready is seen so the DIV leaves EX on the capture edge.
  always_comb begin
    stall_o = 1'b0;
    if (div_valid_i && !flush_i) begin
      case (state_q)
        ST_IDLE:    stall_o = !zero_fast_s;
        ST_BUSY:    stall_o = !div_ready_i;
        ST_RELEASE: stall_o = 1'b1;
        ST_DRAIN:   stall_o = 1'b1;
        default:    stall_o = 1'b1;
      endcase
    end else begin
      stall_o = 1'b0;
    end
  end

  assign div_start_o      = start_q;
  assign div_annul_o      = annul_s;
  assign div_alucontrol_o = ctl_q;
  assign div_op1_o        = op1_q;
  assign div_op2_o        = op2_q;
  assign hilo_we_o        = hilo_we_q;
  assign hi_o             = hi_q;
  assign lo_o             = lo_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam logic [4:0] DIV_CTL  = 5'b11010;
  localparam logic [4:0] DIVU_CTL = 5'b11011;
  localparam int LAT_NORMAL = 35;
  localparam int LAT_ZERO   = 3;

  logic        clk;
  logic        rst;
  logic        div_valid_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic [4:0]  div_alucontrol_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  int n_cmp;
  int n_fail;

  div_issue_ctrl #(.DRAIN_CYCLES(2), .RELEASE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .div_valid_i(div_valid_i), .alucontrol_i(alucontrol_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_alucontrol_o(div_alucontrol_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: computes from the latched operands it is handed.
  function automatic logic [63:0] model_div(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (c == DIV_CTL) begin
      sa = a; sb = b;
      sq = sa / sb; sr = sa % sb;
      return {sr, sq};
    end
    uq = a / b; ur = a % b;
    return {ur, uq};
  endfunction

  int mcnt;
  always @(posedge clk) begin
    if (rst || !div_start_o || div_annul_o) begin
      mcnt        <= 0;
      div_ready_i <= 1'b0;
    end else if (mcnt >= ((div_op2_o == 32'd0) ? LAT_ZERO : LAT_NORMAL)) begin
      div_ready_i  <= 1'b1;
      div_result_i <= model_div(div_alucontrol_o, div_op1_o, div_op2_o);
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge right after the DIV was driven; follows it to completion.
  task automatic wait_done(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit seen_start;
    bit stall_ok;
    n = 0; seen_start = 1'b0; stall_ok = 1'b1;
    #1;
    chk("stall_at_issue", {63'd0, stall_o}, 64'd1);
    while (stall_o && n < 300) begin
      @(negedge clk);
      n++;
      if (div_start_o && !seen_start) begin
        seen_start = 1'b1;
        chk("op1_latched", {32'd0, div_op1_o}, {32'd0, a});
        chk("op2_latched", {32'd0, div_op2_o}, {32'd0, b});
        chk("ctl_latched", {59'd0, div_alucontrol_o}, {59'd0, ctl});
        src_a_i = ~a;
        src_b_i = ~b ^ 32'h0000_0100;
        alucontrol_i = ~ctl;
        #1;
      end
      if (stall_o && div_ready_i) stall_ok = 1'b0;
    end
    chk("wait_bound", {63'd0, (n < 300)}, 64'd1);
    chk("stall_until_ready", {63'd0, stall_ok}, 64'd1);
    chk("start_held", {63'd0, div_start_o}, 64'd1);
    chk("op1_frozen", {32'd0, div_op1_o}, {32'd0, a});
    chk("op2_frozen", {32'd0, div_op2_o}, {32'd0, b});
    @(negedge clk);
    div_valid_i = 1'b0;
    chk("hilo_we", {63'd0, hilo_we_o}, 64'd1);
    chk("hi_lo", {hi_o, lo_o}, {ehi, elo});
    chk("start_dropped", {63'd0, div_start_o}, 64'd0);
    @(negedge clk);
    chk("hilo_we_once", {63'd0, hilo_we_o}, 64'd0);
    n = 0;
    while (busy_o && n < 20) begin @(negedge clk); n++; end
    chk("idle_bound", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b);
    div_valid_i = 1'b1; alucontrol_i = ctl; src_a_i = a; src_b_i = b;
  endtask

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    n_cmp = 0; n_fail = 0;
    vecs[0] = '{DIV_CTL,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[1] = '{DIVU_CTL, 32'd100,       32'd7,          32'd2,         32'd14};
    vecs[2] = '{DIVU_CTL, 32'hFFFF_FFFF, 32'd10,         32'd5,         32'h1999_9999};
    vecs[3] = '{DIV_CTL,  32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vecs[4] = '{DIVU_CTL, 32'd0,         32'd5,          32'd0,         32'd0};

    rst = 1'b1; div_valid_i = 1'b0; alucontrol_i = 5'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    flush_i = 1'b0; div_result_i = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_start", {63'd0, div_start_o}, 64'd0);
    chk("rst_annul", {63'd0, div_annul_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_we", {63'd0, hilo_we_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);

    // Table-driven divides.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(vecs[i].ctl, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Flush mid-divide, then a clean DIVU 9/3.
    @(negedge clk);
    drive(DIVU_CTL, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_annul", {63'd0, div_annul_o}, 64'd1);
    chk("flush_nostall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    flush_i = 1'b0; div_valid_i = 1'b0;
    chk("annul_one_cycle", {63'd0, div_annul_o}, 64'd0);
    chk("flush_start_low", {63'd0, div_start_o}, 64'd0);
    chk("flush_no_we", {63'd0, hilo_we_o}, 64'd0);
    chk("drain1_busy", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    chk("drain2_busy", {63'd0, busy_o}, 64'd1);
    chk("drain_no_we", {63'd0, hilo_we_o}, 64'd0);
    @(negedge clk);
    chk("drain_done", {63'd0, busy_o}, 64'd0);
    drive(DIVU_CTL, 32'd9, 32'd3);
    wait_done(DIVU_CTL, 32'd9, 32'd3, 32'd0, 32'd3);

    // Back-to-back: second DIV arrives in RELEASE while stale ready is still up.
    @(negedge clk);
    drive(DIVU_CTL, 32'd50, 32'd8);
    #1;
    begin : b2b
      int n;
      n = 0;
      while (stall_o && n < 300) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("b2b1_we", {63'd0, hilo_we_o}, 64'd1);
      chk("b2b1_hilo", {hi_o, lo_o}, {32'd2, 32'd6});
      drive(DIV_CTL, 32'hFFFF_FFEC, 32'd3);
      #1;
      chk("b2b_release_stall", {63'd0, stall_o}, 64'd1);
      chk("b2b_release_nostart", {63'd0, div_start_o}, 64'd0);
      @(negedge clk);
      chk("b2b_idle_nostart", {63'd0, div_start_o}, 64'd0);
      chk("b2b_no_stale_we", {63'd0, hilo_we_o}, 64'd0);
      chk("b2b_idle", {63'd0, busy_o}, 64'd0);
      wait_done(DIV_CTL, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA);
    end

    // Zero divisor.
    @(negedge clk);
    drive(DIV_CTL, 32'h0000_1234, 32'd0);
`ifdef DIV_ZERO_FAST_EN
    #1;
    chk("z_nostall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    div_valid_i = 1'b0;
    chk("z_we", {63'd0, hilo_we_o}, 64'd1);
    chk("z_hilo", {hi_o, lo_o}, {32'h0000_1234, 32'hFFFF_FFFF});
    chk("z_nostart", {63'd0, div_start_o}, 64'd0);
    chk("z_idle", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    chk("z_we_once", {63'd0, hilo_we_o}, 64'd0);
`else
    wait_done(DIV_CTL, 32'h0000_1234, 32'd0, 32'd0, 32'd0);
`endif

    // Reset in BUSY, then a fresh divide.
    @(negedge clk);
    drive(DIVU_CTL, 32'd77, 32'd5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; div_valid_i = 1'b0;
    chk("rbusy_start", {63'd0, div_start_o}, 64'd0);
    chk("rbusy_busy", {63'd0, busy_o}, 64'd0);
    chk("rbusy_we", {63'd0, hilo_we_o}, 64'd0);
    chk("rbusy_hilo", {hi_o, lo_o}, 64'd0);
    chk("rbusy_ops", {div_op1_o, div_op2_o}, 64'd0);
    @(negedge clk);
    chk("rbusy_no_late_we", {63'd0, hilo_we_o}, 64'd0);
    drive(DIVU_CTL, 32'd77, 32'd5);
    wait_done(DIVU_CTL, 32'd77, 32'd5, 32'd2, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
